// File: rtl/latch_bank_writer.sv
// Write sequencer for a transparent-high latch bank: present data, pulse one enable, hold data.
// state | meaning
// IDLE  | waiting for a request; LAT_D keeps the last written word
// SETUP | LAT_D driven, all enables low, counting the setup window
// OPEN  | exactly one enable high, counting the transparent window
// HOLD  | enables low again, LAT_D held, counting the hold window
module latch_bank_writer #(
    parameter int WORDS     = 8,
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [WIDTH-1:0]  WR_DATA,
    output logic [WIDTH-1:0]  LAT_D,
    output logic [WORDS-1:0]  LAT_EN,
    output logic              BUSY,
    output logic              ERR
);

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    localparam logic [ADDR_W:0]  WORDS_LIM = (ADDR_W+1)'(WORDS);
    localparam logic [7:0]       SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0]       OPEN_LD   = 8'(OPEN_CYC - 1);
    localparam logic [7:0]       HOLD_LD   = 8'(HOLD_CYC - 1);
    localparam logic [WORDS-1:0] EN_ONE    = WORDS'(1);

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [WIDTH-1:0]  d_nxt;
    logic [WORDS-1:0]  en_nxt;
    logic              err_nxt;
    logic              accept;
    logic              in_range;

    // The ERR cycle after a dropped request also blocks acceptance.
    assign WR_READY = (state == IDLE) && !ERR && !RST;
    assign accept   = WR_VALID && WR_READY;
    assign in_range = {1'b0, WR_ADDR} < WORDS_LIM;
    assign BUSY     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        d_nxt     = LAT_D;
        en_nxt    = LAT_EN;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                en_nxt = '0;
                if (accept) begin
                    if (in_range) begin
                        addr_nxt  = WR_ADDR;
                        d_nxt     = WR_DATA;
                        cnt_nxt   = SETUP_LD;
                        state_nxt = SETUP;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SETUP: begin
                en_nxt = '0;
                if (cnt == 8'd0) begin
                    en_nxt    = EN_ONE << addr_q;
                    cnt_nxt   = OPEN_LD;
                    state_nxt = OPEN;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            OPEN: begin
                if (cnt == 8'd0) begin
                    en_nxt    = '0;
                    cnt_nxt   = HOLD_LD;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HOLD: begin
                en_nxt = '0;
                if (cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                en_nxt    = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            addr_q <= '0;
            LAT_D  <= '0;
            LAT_EN <= '0;
            ERR    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            LAT_D  <= d_nxt;
            LAT_EN <= en_nxt;
            ERR    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_latch_bank_writer.sv
// Bench for latch_bank_writer: three instances with different window lengths and bank sizes,
// driven from one cycle-by-cycle vector table with hand-derived expected outputs.
module tb_latch_bank_writer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst [3];
    logic       vld [3];
    logic [2:0] adr [3];
    logic [7:0] dat [3];

    logic       rdy_a, bsy_a, err_a;
    logic [7:0] d_a, en_a;
    logic       rdy_b, bsy_b, err_b;
    logic [7:0] d_b, en_b;
    logic       rdy_c, bsy_c, err_c;
    logic [7:0] d_c;
    logic [5:0] en_c;

    // A: defaults, B: longer windows, C: 6-word bank with a 4-cycle open window
    latch_bank_writer #(.WORDS(8), .WIDTH(8), .ADDR_W(3), .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1)) u_a (
        .CLK(CLK), .RST(rst[0]), .WR_VALID(vld[0]), .WR_READY(rdy_a), .WR_ADDR(adr[0]),
        .WR_DATA(dat[0]), .LAT_D(d_a), .LAT_EN(en_a), .BUSY(bsy_a), .ERR(err_a));
    latch_bank_writer #(.WORDS(8), .WIDTH(8), .ADDR_W(3), .SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) u_b (
        .CLK(CLK), .RST(rst[1]), .WR_VALID(vld[1]), .WR_READY(rdy_b), .WR_ADDR(adr[1]),
        .WR_DATA(dat[1]), .LAT_D(d_b), .LAT_EN(en_b), .BUSY(bsy_b), .ERR(err_b));
    latch_bank_writer #(.WORDS(6), .WIDTH(8), .ADDR_W(3), .SETUP_CYC(1), .OPEN_CYC(4), .HOLD_CYC(1)) u_c (
        .CLK(CLK), .RST(rst[2]), .WR_VALID(vld[2]), .WR_READY(rdy_c), .WR_ADDR(adr[2]),
        .WR_DATA(dat[2]), .LAT_D(d_c), .LAT_EN(en_c), .BUSY(bsy_c), .ERR(err_c));

    typedef struct {
        logic       rdy;
        logic       bsy;
        logic       err;
        logic [7:0] d;
        logic [7:0] en;
    } obs_t;

    typedef struct {
        int         sel;
        logic       rst;
        logic       vld;
        logic [2:0] adr;
        logic [7:0] dat;
        obs_t       exp;
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic       prev_b [3];
    logic [7:0] prev_d [3];

    function automatic void add(int sel, logic r, logic v, logic [2:0] a, logic [7:0] dt,
                                logic rd, logic b, logic e, logic [7:0] d, logic [7:0] en);
        vec_t x;
        x.sel = sel; x.rst = r; x.vld = v; x.adr = a; x.dat = dt;
        x.exp.rdy = rd; x.exp.bsy = b; x.exp.err = e; x.exp.d = d; x.exp.en = en;
        vecs.push_back(x);
    endfunction

    function automatic obs_t get_out(int sel);
        obs_t o;
        case (sel)
            0:       begin o.rdy = rdy_a; o.bsy = bsy_a; o.err = err_a; o.d = d_a; o.en = en_a; end
            1:       begin o.rdy = rdy_b; o.bsy = bsy_b; o.err = err_b; o.d = d_b; o.en = en_b; end
            default: begin o.rdy = rdy_c; o.bsy = bsy_c; o.err = err_c; o.d = d_c; o.en = {2'b00, en_c}; end
        endcase
        return o;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic inv_check(input int idx);
        obs_t o;
        for (int s = 0; s < 3; s++) begin
            o = get_out(s);
            chk($sformatf("onehot[%0d]", s), idx, 8'($countones(o.en) <= 1), 8'd1);
            if (o.rdy)
                chk($sformatf("ready_en_low[%0d]", s), idx, o.en, 8'h00);
            if (prev_b[s] && o.bsy)
                chk($sformatf("d_stable[%0d]", s), idx, o.d, prev_d[s]);
            prev_b[s] = o.bsy;
            prev_d[s] = o.d;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        obs_t o, e;
        @(negedge CLK);
        for (int s = 0; s < 3; s++) begin
            rst[s] = 1'b0;
            vld[s] = 1'b0;
        end
        rst[v.sel] = v.rst;
        vld[v.sel] = v.vld;
        adr[v.sel] = v.adr;
        dat[v.sel] = v.dat;
        sb.push_back(v.exp);
        @(posedge CLK);
        #1;
        o = get_out(v.sel);
        e = sb.pop_front();
        chk("ready", idx, 8'(o.rdy), 8'(e.rdy));
        chk("busy",  idx, 8'(o.bsy), 8'(e.bsy));
        chk("err",   idx, 8'(o.err), 8'(e.err));
        chk("lat_d", idx, o.d, e.d);
        chk("lat_en", idx, o.en, e.en);
        inv_check(idx);
    endtask

    initial begin
        obs_t o;
        logic [7:0] dk;
        for (int s = 0; s < 3; s++) begin
            rst[s] = 1'b1; vld[s] = 1'b0; adr[s] = 3'd0; dat[s] = 8'd0;
            prev_b[s] = 1'b0; prev_d[s] = 8'd0;
        end

        // A: reset state, then single write addr 3 / 0xA5
        add(0, 1, 0, 3'd0, 8'h00,  0, 0, 0, 8'h00, 8'h00);
        add(0, 0, 0, 3'd0, 8'h00,  1, 0, 0, 8'h00, 8'h00);
        add(0, 0, 1, 3'd3, 8'hA5,  0, 1, 0, 8'hA5, 8'h00);
        add(0, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'hA5, 8'h08);
        add(0, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'hA5, 8'h00);
        add(0, 0, 0, 3'd0, 8'h00,  1, 0, 0, 8'hA5, 8'h00);
        // A: WR_VALID held high, addresses 0..7, junk on the ignored cycles
        for (int k = 0; k < 8; k++) begin
            dk = 8'(k * 17);
            add(0, 0, 1, 3'(k),     dk,    0, 1, 0, dk, 8'h00);
            add(0, 0, 1, 3'(7 - k), 8'hEE, 0, 1, 0, dk, 8'(1 << k));
            add(0, 0, 1, 3'(7 - k), 8'hEE, 0, 1, 0, dk, 8'h00);
            add(0, 0, 1, 3'(7 - k), 8'hEE, 1, 0, 0, dk, 8'h00);
        end
        add(0, 0, 0, 3'd0, 8'h00,  1, 0, 0, 8'h77, 8'h00);
        // B: setup 2, open 3, hold 2, addr 7 / 0x3C
        add(1, 0, 1, 3'd7, 8'h3C,  0, 1, 0, 8'h3C, 8'h00);
        add(1, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h3C, 8'h00);
        add(1, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h3C, 8'h80);
        add(1, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h3C, 8'h80);
        add(1, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h3C, 8'h80);
        add(1, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h3C, 8'h00);
        add(1, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h3C, 8'h00);
        add(1, 0, 0, 3'd0, 8'h00,  1, 0, 0, 8'h3C, 8'h00);
        // C: out-of-range addr 6 dropped, then addr 5 completes with a 4-cycle open window
        add(2, 0, 1, 3'd6, 8'hFF,  0, 0, 1, 8'h00, 8'h00);
        add(2, 0, 0, 3'd0, 8'h00,  1, 0, 0, 8'h00, 8'h00);
        add(2, 0, 1, 3'd5, 8'h96,  0, 1, 0, 8'h96, 8'h00);
        add(2, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h96, 8'h20);
        add(2, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h96, 8'h20);
        add(2, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h96, 8'h20);
        add(2, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h96, 8'h20);
        add(2, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h96, 8'h00);
        add(2, 0, 0, 3'd0, 8'h00,  1, 0, 0, 8'h96, 8'h00);
        // C: addr 7 held across the ERR cycle is taken only once
        add(2, 0, 1, 3'd7, 8'h11,  0, 0, 1, 8'h96, 8'h00);
        add(2, 0, 1, 3'd7, 8'h22,  1, 0, 0, 8'h96, 8'h00);
        add(2, 0, 0, 3'd0, 8'h00,  1, 0, 0, 8'h96, 8'h00);
        // C: reset while the enable is open
        add(2, 0, 1, 3'd2, 8'h4B,  0, 1, 0, 8'h4B, 8'h00);
        add(2, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h4B, 8'h04);
        add(2, 0, 0, 3'd0, 8'h00,  0, 1, 0, 8'h4B, 8'h04);
        add(2, 1, 0, 3'd0, 8'h00,  0, 0, 0, 8'h00, 8'h00);
        add(2, 0, 0, 3'd0, 8'h00,  1, 0, 0, 8'h00, 8'h00);

        repeat (2) @(posedge CLK);
        #1;
        for (int s = 0; s < 3; s++) begin
            o = get_out(s);
            chk($sformatf("rst_ready[%0d]", s), -1, 8'(o.rdy), 8'h00);
            chk($sformatf("rst_busy[%0d]",  s), -1, 8'(o.bsy), 8'h00);
            chk($sformatf("rst_err[%0d]",   s), -1, 8'(o.err), 8'h00);
            chk($sformatf("rst_d[%0d]",     s), -1, o.d,       8'h00);
            chk($sformatf("rst_en[%0d]",    s), -1, o.en,      8'h00);
        end

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
